// File: rtl/score_digit_ctrl_pkg.sv
// Shared types and constants for the score digit controller slice.
package score_pkg;

  typedef enum logic [1:0] {IDLE, CONV, COMMIT} state_t;

  localparam int unsigned DIGITS  = 4;
  localparam logic [3:0]  BLANK   = 4'hF;
  localparam logic [13:0] MAX_VAL = 14'd9999;
  localparam int unsigned ITER    = 14;

  // Double-dabble correction: add 3 to every BCD nibble that is 5 or more.
  function automatic logic [15:0] dabble_adj(input logic [15:0] b);
    logic [15:0] r;
    r = b;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (r[4*i +: 4] >= 4'd5) r[4*i +: 4] = r[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

endpackage

// File: rtl/score_digit_ctrl_bin2bcd.sv
// Sequential double-dabble: one shift per cycle, done pulses in the COMMIT cycle.
module bin2bcd_seq
  import score_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [13:0] bin,
  output logic        done,
  output logic [15:0] bcd
);

  state_t      state;
  logic [13:0] sh;
  logic [3:0]  cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      sh    <= '0;
      bcd   <= '0;
      cnt   <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            sh    <= bin;
            bcd   <= '0;
            cnt   <= '0;
            state <= CONV;
          end
        end
        CONV: begin
          {bcd, sh} <= {dabble_adj(bcd), sh} << 1;
          cnt       <= cnt + 4'd1;
          if (cnt == 4'(ITER - 1)) begin
            state <= COMMIT;
            done  <= 1'b1;
          end
        end
        COMMIT:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/score_digit_ctrl.sv
// Load/busy wrapper around bin2bcd_seq, atomic display register and per-pixel digit select.
module score_digit_ctrl
  import score_pkg::*;
#(
  parameter int unsigned ORG_X    = 100,
  parameter int unsigned ORG_Y    = 50,
  parameter int unsigned PITCH    = 8,
  parameter bit          BLANK_LZ = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [13:0] value,
  output logic        busy,
  output logic        ovf,
  input  logic [10:0] poX,
  input  logic [10:0] poY,
  output logic [3:0]  glyph_num,
  output logic [10:0] glyph_x,
  output logic [10:0] glyph_y
);

  localparam int unsigned SHIFT = $clog2(PITCH);
  localparam logic [11:0] X0    = 12'(ORG_X);
  localparam logic [11:0] SPAN  = 12'(4 * PITCH);

  logic        start, done;
  logic [13:0] bin;
  logic [15:0] bcd, disp;
  logic        poy_unused;

  assign poy_unused = ^poY;
  assign start      = load && !busy;
  assign bin        = (value > MAX_VAL) ? MAX_VAL : value;

  bin2bcd_seq u_conv (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .bin   (bin),
    .done  (done),
    .bcd   (bcd)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy <= 1'b0;
      ovf  <= 1'b0;
      disp <= '0;
    end else if (start) begin
      busy <= 1'b1;
      ovf  <= (value > MAX_VAL);
    end else if (done) begin
      busy <= 1'b0;
      disp <= bcd;
    end
  end

  logic [11:0] dx;
  logic        in_field;
  logic [1:0]  slot;
  logic [3:0]  blank;
  logic [3:0]  sel;

  // 12-bit subtract: a poX left of ORG_X fails the >= test instead of wrapping.
  always_comb begin
    dx       = {1'b0, poX} - X0;
    in_field = ({1'b0, poX} >= X0) && (dx < SPAN);
    slot     = 2'(dx >> SHIFT);
    blank    = '0;
    if (BLANK_LZ) begin
      blank[3] = (disp[15:12] == 4'd0);
      blank[2] = blank[3] && (disp[11:8] == 4'd0);
      blank[1] = blank[2] && (disp[7:4] == 4'd0);
    end
    sel = blank[3 - slot] ? BLANK : disp[4*(3 - slot) +: 4];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      glyph_num <= BLANK;
      glyph_x   <= '0;
      glyph_y   <= '0;
    end else if (in_field) begin
      glyph_num <= sel;
      glyph_x   <= 11'(ORG_X) + (11'(slot) << SHIFT);
      glyph_y   <= 11'(ORG_Y);
    end else begin
      glyph_num <= BLANK;
      glyph_x   <= '0;
      glyph_y   <= '0;
    end
  end

endmodule

// File: tb/tb_score_digit_ctrl.sv
// Directed bench for score_digit_ctrl, with a second instance using BLANK_LZ=0.
module tb_score_digit_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        load = 1'b0;
  logic [13:0] value = '0;
  logic [10:0] poX = '0;
  logic [10:0] poY = '0;

  logic        busy, ovf, busy2, ovf2;
  logic [3:0]  glyph_num, glyph_num2;
  logic [10:0] glyph_x, glyph_y, glyph_x2, glyph_y2;

  int checks = 0;
  int failures = 0;
  int cnt;

  always #5 clk = ~clk;

  score_digit_ctrl #(.ORG_X(100), .ORG_Y(50), .PITCH(8), .BLANK_LZ(1'b1)) dut (
    .clk(clk), .rst(rst), .load(load), .value(value), .busy(busy), .ovf(ovf),
    .poX(poX), .poY(poY), .glyph_num(glyph_num), .glyph_x(glyph_x), .glyph_y(glyph_y)
  );

  score_digit_ctrl #(.ORG_X(100), .ORG_Y(50), .PITCH(8), .BLANK_LZ(1'b0)) dut_nb (
    .clk(clk), .rst(rst), .load(load), .value(value), .busy(busy2), .ovf(ovf2),
    .poX(poX), .poY(poY), .glyph_num(glyph_num2), .glyph_x(glyph_x2), .glyph_y(glyph_y2)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pix(input logic [10:0] x);
    poX = x;
    tick();
  endtask

  // Pulse load for one edge, then wait (bounded) for busy to drop; returns busy cycle count.
  task automatic do_load(input logic [13:0] v, output int n);
    value = v;
    load  = 1'b1;
    tick();
    load = 1'b0;
    n = 0;
    while (busy && n < 100) begin
      n++;
      tick();
    end
  endtask

  initial begin
    poX = 11'd124;
    repeat (3) tick();
    check("rst_busy", 16'(busy), 16'd0);
    check("rst_ovf", 16'(ovf), 16'd0);
    check("rst_gnum", 16'(glyph_num), 16'hF);
    check("rst_gx", 16'(glyph_x), 16'd0);
    check("rst_gy", 16'(glyph_y), 16'd0);
    rst = 1'b1;
    pix(11'd124);
    check("post_rst_gnum", 16'(glyph_num), 16'd0);
    check("post_rst_gx", 16'(glyph_x), 16'd124);

    // 1234
    do_load(14'd1234, cnt);
    check("busy_len_1234", 16'(cnt), 16'd15);
    pix(11'd108);
    check("1234_s1_num", 16'(glyph_num), 16'd2);
    check("1234_s1_x", 16'(glyph_x), 16'd108);
    check("1234_s1_y", 16'(glyph_y), 16'd50);
    pix(11'd127);
    check("1234_s3_num", 16'(glyph_num), 16'd4);
    check("1234_s3_x", 16'(glyph_x), 16'd124);
    pix(11'd100);
    check("1234_s0_num", 16'(glyph_num), 16'd1);
    pix(11'd116);
    check("1234_s2_num", 16'(glyph_num), 16'd3);

    // 7 with leading-zero blanking
    do_load(14'd7, cnt);
    check("busy_len_7", 16'(cnt), 16'd15);
    pix(11'd100);
    check("7_s0_blank", 16'(glyph_num), 16'hF);
    check("7_s0_x", 16'(glyph_x), 16'd100);
    check("7_nb_s0", 16'(glyph_num2), 16'd0);
    pix(11'd108);
    check("7_s1_blank", 16'(glyph_num), 16'hF);
    pix(11'd116);
    check("7_s2_blank", 16'(glyph_num), 16'hF);
    pix(11'd124);
    check("7_s3_num", 16'(glyph_num), 16'd7);

    // Overflow clamp
    value = 14'd12000;
    load  = 1'b1;
    tick();
    load = 1'b0;
    check("ovf_set", 16'(ovf), 16'd1);
    cnt = 0;
    while (busy && cnt < 100) begin cnt++; tick(); end
    check("busy_len_ovf", 16'(cnt), 16'd15);
    pix(11'd100); check("9999_s0", 16'(glyph_num), 16'd9);
    pix(11'd108); check("9999_s1", 16'(glyph_num), 16'd9);
    pix(11'd116); check("9999_s2", 16'(glyph_num), 16'd9);
    pix(11'd124); check("9999_s3", 16'(glyph_num), 16'd9);
    value = 14'd5;
    load  = 1'b1;
    tick();
    load = 1'b0;
    check("ovf_clear", 16'(ovf), 16'd0);
    cnt = 0;
    while (busy && cnt < 100) begin cnt++; tick(); end
    check("busy_len_5", 16'(cnt), 16'd15);

    // Load while busy is dropped
    value = 14'd42;
    load  = 1'b1;
    tick();
    load = 1'b0;
    tick();
    tick();
    value = 14'd5555;
    load  = 1'b1;
    tick();
    load = 1'b0;
    check("busy_during", 16'(busy), 16'd1);
    cnt = 0;
    while (busy && cnt < 100) begin cnt++; tick(); end
    check("busy_len_42", 16'(cnt), 16'd12);
    tick();
    check("no_queue", 16'(busy), 16'd0);
    pix(11'd100); check("42_s0", 16'(glyph_num), 16'hF);
    check("42_nb_s0", 16'(glyph_num2), 16'd0);
    pix(11'd108); check("42_s1", 16'(glyph_num), 16'hF);
    pix(11'd116); check("42_s2", 16'(glyph_num), 16'd4);
    pix(11'd124); check("42_s3", 16'(glyph_num), 16'd2);

    // Field boundaries
    pix(11'd99);
    check("x99_num", 16'(glyph_num), 16'hF);
    check("x99_x", 16'(glyph_x), 16'd0);
    pix(11'd132);
    check("x132_num", 16'(glyph_num), 16'hF);
    check("x132_x", 16'(glyph_x), 16'd0);
    check("x132_y", 16'(glyph_y), 16'd0);
    pix(11'd131);
    check("x131_x", 16'(glyph_x), 16'd124);
    pix(11'd0);
    check("x0_num", 16'(glyph_num), 16'hF);

    // Abort mid-conversion
    poX   = 11'd124;
    value = 14'd8888;
    load  = 1'b1;
    tick();
    load = 1'b0;
    repeat (7) tick();
    check("abort_busy_pre", 16'(busy), 16'd1);
    rst = 1'b0;
    #1;
    check("abort_busy", 16'(busy), 16'd0);
    check("abort_gnum", 16'(glyph_num), 16'hF);
    tick();
    rst = 1'b1;
    repeat (20) tick();
    check("abort_idle", 16'(busy), 16'd0);
    pix(11'd116); check("abort_s2", 16'(glyph_num), 16'hF);
    pix(11'd124); check("abort_s3", 16'(glyph_num), 16'd0);
    check("abort_nb_s3", 16'(glyph_num2), 16'd0);
    pix(11'd100); check("abort_nb_s0", 16'(glyph_num2), 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/score_digit_ctrl.md
# score_digit_ctrl

Controller that feeds the 6×6 digit-glyph renderer on the VGA path. It accepts a binary score with a load/busy handshake and converts it to four BCD digits with a sequential double-dabble. It commits the digits atomically to a display register. Per pixel, it tells the renderer which digit and glyph origin apply at the current scan position, with optional leading-zero blanking.

## Interface
Parameters:
- ORG_X, 100: x of left edge of leftmost (thousands) glyph
- ORG_Y, 50: glyph base row passed as renderer y (renderer draws rows y..y-5)
- PITCH, 8: horizontal digit spacing in pixels; power of two, ≥6
- BLANK_LZ, 1: 1 = blank leading zeros (units digit never blanked)

Ports:
- clk  input  1  system clock
- rst  input  1  reset; asynchronous, active-low
- load  input  1  one-cycle request to convert `value`
- value  input  14  binary score
- busy  output  1  conversion in progress; `load` ignored while high
- ovf  output  1  last loaded value exceeded 9999
- poX  input  11  current pixel column
- poY  input  11  current pixel row (accepted for interface symmetry, unused)
- glyph_num  output  4  digit to render; 4'hF = blank
- glyph_x  output  11  glyph origin x for renderer
- glyph_y  output  11  glyph base row for renderer

## Operation
- Reset (rst low, any state) forces all state and outputs to their reset values:
  - FSM IDLE, busy 0, ovf 0, display digits 0,0,0,0
  - glyph_num 4'hF, glyph_x 0, glyph_y 0
  - An in-flight conversion is discarded.
- FSM states: IDLE, CONV, COMMIT.
- IDLE, load=1:
  - Latch min(value, 9999).
  - Set ovf = (value > 9999).
  - Clear the 16-bit BCD accumulator and iteration counter to 0.
  - Go to CONV.
- CONV, one iteration per cycle:
  - Add 3 to each BCD nibble ≥ 5.
  - Shift {bcd, bin} left by 1.
  - After the 14th iteration, go to COMMIT.
- COMMIT: copy the accumulator to the display digits d3..d0 in one cycle, then go to IDLE.
- Display digits change only in COMMIT; the scan never sees a partial result.
- load in CONV/COMMIT is dropped; no queueing.
- Pixel path, registered every cycle:
  - If ORG_X ≤ poX < ORG_X+4·PITCH:
    - slot = (poX−ORG_X) >> log2(PITCH), 0..3; slot 0 = d3.
    - glyph_x = ORG_X + slot·PITCH.
    - glyph_y = ORG_Y.
    - glyph_num = selected digit, or 4'hF if blanked.
  - Otherwise glyph_num = 4'hF, glyph_x = 0, glyph_y = 0.
- Blanking (BLANK_LZ=1): digit k (k = 3, 2, 1) is blanked iff it and all more-significant digits are zero. d0 is always shown.
- Arithmetic widths:
  - poX compare and subtract use 12 bits, so poX < ORG_X never wraps into the field.
  - glyph_x is 11 bits; ORG_X+4·PITCH ≤ 2047 is required.

## Timing
- Handshake: load sampled at edge N → busy=1 from N through N+14 (15 cycles). Display updated and busy=0 after edge N+15.
- A new load is accepted at the first edge where busy=0 is sampled.
- ovf updates at edge N, not at COMMIT.
- Pixel path latency: 1 cycle from poX to glyph_*. The renderer adds 1 more, so pic lags poX by 2 cycles; the pixel pipeline upstream compensates.
- Simultaneous COMMIT and an in-field pixel: the pixel registered on the COMMIT edge uses the old digits; the next cycle uses the new ones.

## Structure
- Package score_pkg:
  - state enum {IDLE, CONV, COMMIT}
  - DIGITS=4, BLANK=4'hF, MAX_VAL=14'd9999, ITER=14
- Sub-module bin2bcd_seq: iterative double-dabble with start/done/bin/bcd ports; the FSM and counter live inside it.
- score_digit_ctrl keeps the load/busy wrapper, display register, blanking and slot select.

## Test plan
- Reset with rst low mid-scan → busy 0, ovf 0, glyph_num F, glyph_x 0, glyph_y 0; after release, poX=124 → glyph_num 0 next cycle.
- load value=1234 → busy high exactly 15 cycles; then poX=108 → glyph_num 2, glyph_x 108, glyph_y 50; poX=127 → glyph_num 4, glyph_x 124.
- load 7, BLANK_LZ=1 → poX=100, 108, 116 give glyph_num F; poX=124 gives 7. With BLANK_LZ=0, poX=100 gives 0.
- load 12000 → ovf=1 one cycle later; display 9,9,9,9. Then load 5 → ovf=0.
- load 42, then load 5555 three cycles later → second load ignored; display 0,0,4,2.
- Edge cases and abort:
  - poX=99 or poX=132 → glyph_num F, glyph_x 0.
  - rst pulsed low at iteration 7 of loading 8888 → busy 0, display all 0.
